// File: rtl/disp_timing_gen.sv
// Raster timing generator: programmable DE/HSYNC/VSYNC with double-buffered mode set.
// Optional DISP_TG_LINE_IRQ_EN adds a per-frame line interrupt strobe.
module disp_timing_gen #(
    parameter int CNT_W = 13
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic             tg_enable,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    input  logic             cfg_update,
`ifdef DISP_TG_LINE_IRQ_EN
    input  logic [CNT_W-1:0] cfg_irq_line,
    output logic             line_irq,
`endif
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int SW = CNT_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [SW-1:0]    sum_t;

    typedef struct packed {
        cnt_t ha;
        cnt_t hf;
        cnt_t hs;
        cnt_t hb;
        cnt_t va;
        cnt_t vf;
        cnt_t vs;
        cnt_t vb;
    } tset_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    localparam sum_t MAXT = sum_t'(1) << CNT_W;

    function automatic sum_t f_ext(cnt_t c);
        return {2'b00, c};
    endfunction

    function automatic sum_t f_ht(tset_t s);
        return f_ext(s.ha) + f_ext(s.hf) + f_ext(s.hs) + f_ext(s.hb);
    endfunction

    function automatic sum_t f_vt(tset_t s);
        return f_ext(s.va) + f_ext(s.vf) + f_ext(s.vs) + f_ext(s.vb);
    endfunction

    function automatic logic f_legal(tset_t s);
        return (s.ha != '0) && (s.hf != '0) && (s.hs != '0) && (s.hb != '0)
            && (s.va != '0) && (s.vf != '0) && (s.vs != '0) && (s.vb != '0)
            && (f_ht(s) <= MAXT) && (f_vt(s) <= MAXT);
    endfunction

    state_t r_state;
    tset_t  r_sh;
    tset_t  r_act;
    logic   r_pending;
    logic   r_err;
    logic   r_retry;
    cnt_t   r_h;
    cnt_t   r_v;

    tset_t  w_cfg;
    logic   w_sh_ok;
    logic   w_h_last;
    logic   w_v_last;
    state_t w_state_nx;
    logic   w_load;
    logic   w_run;
    logic   w_err_nx;
    logic   w_retry_nx;
    cnt_t   w_h_nx;
    cnt_t   w_v_nx;
    tset_t  w_set_nx;
    sum_t   w_hx;
    sum_t   w_vx;
    sum_t   w_ht_nx;
    sum_t   w_vt_nx;
    sum_t   w_hs_lo;
    sum_t   w_hs_hi;
    sum_t   w_vs_lo;
    sum_t   w_vs_hi;
    logic   w_de;
    logic   w_hs_on;
    logic   w_vs_on;
    logic   w_ls;
    logic   w_fs;
    logic   w_fe;

    assign w_cfg = {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                    cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp};

    assign w_sh_ok  = f_legal(r_sh);
    assign w_h_last = f_ext(r_h) == f_ht(r_act) - sum_t'(1);
    assign w_v_last = f_ext(r_v) == f_vt(r_act) - sum_t'(1);

    assign cfg_pending = r_pending;
    assign cfg_err     = r_err;

    // Next counter position and state; outputs below are derived from these
    // so the registered outputs line up with the registered counters.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_run      = 1'b0;
        w_err_nx   = r_err;
        w_retry_nx = r_retry;
        w_h_nx     = '0;
        w_v_nx     = '0;
        if (!tg_enable) begin
            w_state_nx = S_IDLE;
            w_retry_nx = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nx = S_LOAD;
                S_LOAD: begin
                    if (!r_retry || r_pending) begin
                        w_load = 1'b1;
                        if (w_sh_ok) begin
                            w_state_nx = S_RUN;
                            w_run      = 1'b1;
                            w_err_nx   = 1'b0;
                            w_retry_nx = 1'b0;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_retry_nx = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    w_run = 1'b1;
                    if (w_h_last && w_v_last) begin
                        if (r_pending) begin
                            w_load = 1'b1;
                            if (w_sh_ok) begin
                                w_err_nx = 1'b0;
                            end else begin
                                w_run      = 1'b0;
                                w_err_nx   = 1'b1;
                                w_retry_nx = 1'b1;
                                w_state_nx = S_LOAD;
                            end
                        end
                    end else if (w_h_last) begin
                        w_v_nx = r_v + cnt_t'(1);
                    end else begin
                        w_h_nx = r_h + cnt_t'(1);
                        w_v_nx = r_v;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_set_nx = w_load ? r_sh : r_act;
        w_hx     = f_ext(w_h_nx);
        w_vx     = f_ext(w_v_nx);
        w_ht_nx  = f_ht(w_set_nx);
        w_vt_nx  = f_vt(w_set_nx);
        w_hs_lo  = f_ext(w_set_nx.ha) + f_ext(w_set_nx.hf);
        w_hs_hi  = w_hs_lo + f_ext(w_set_nx.hs);
        w_vs_lo  = f_ext(w_set_nx.va) + f_ext(w_set_nx.vf);
        w_vs_hi  = w_vs_lo + f_ext(w_set_nx.vs);
        w_de     = w_run && (w_h_nx < w_set_nx.ha) && (w_v_nx < w_set_nx.va);
        w_hs_on  = w_run && (w_hx >= w_hs_lo) && (w_hx < w_hs_hi);
        w_vs_on  = w_run && (w_vx >= w_vs_lo) && (w_vx < w_vs_hi);
        w_ls     = w_run && (w_h_nx == '0);
        w_fs     = w_ls && (w_v_nx == '0);
        w_fe     = w_run && (w_hx == w_ht_nx - sum_t'(1))
                         && (w_vx == w_vt_nx - sum_t'(1));
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_act       <= '0;
            r_pending   <= 1'b0;
            r_err       <= 1'b0;
            r_retry     <= 1'b0;
            r_h         <= '0;
            r_v         <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
`ifdef DISP_TG_LINE_IRQ_EN
            line_irq    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_err   <= w_err_nx;
            r_retry <= w_retry_nx;
            r_h     <= w_h_nx;
            r_v     <= w_v_nx;
            if (cfg_update) begin
                r_sh <= w_cfg;
            end
            if (w_load) begin
                r_act <= r_sh;
            end
            // A capture on the reload edge survives for the next boundary.
            r_pending   <= cfg_update | (r_pending & ~w_load);
            de          <= w_de;
            hsync       <= cfg_hs_pol ? w_hs_on : ~w_hs_on;
            vsync       <= cfg_vs_pol ? w_vs_on : ~w_vs_on;
            pix_x       <= w_de ? w_h_nx : '0;
            pix_y       <= w_de ? w_v_nx : '0;
            line_start  <= w_ls;
            frame_start <= w_fs;
            frame_end   <= w_fe;
`ifdef DISP_TG_LINE_IRQ_EN
            line_irq    <= w_ls && (w_v_nx == cfg_irq_line);
`endif
        end
    end

endmodule

// File: tb/tb_disp_timing_gen.sv
// Bench for disp_timing_gen: table of timing modes plus mode-change sequences.
// Expected outputs come from a raster model keyed on cycle index.
module tb_disp_timing_gen;

    localparam int W = 13;
    localparam int IRQ_LINE = 3;

    logic         pixel_clk = 1'b0;
    logic         rst_n;
    logic         tg_enable;
    logic [W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic         cfg_hs_pol, cfg_vs_pol, cfg_update;
    logic         cfg_pending, cfg_err, de, hsync, vsync;
    logic [W-1:0] pix_x, pix_y;
    logic         line_start, frame_start, frame_end;
`ifdef DISP_TG_LINE_IRQ_EN
    logic [W-1:0] cfg_irq_line;
    logic         line_irq;
`endif

    always #5 pixel_clk = ~pixel_clk;

    disp_timing_gen #(.CNT_W(W)) dut (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .tg_enable    (tg_enable),
        .cfg_h_active (cfg_h_active),
        .cfg_h_fp     (cfg_h_fp),
        .cfg_h_sync   (cfg_h_sync),
        .cfg_h_bp     (cfg_h_bp),
        .cfg_v_active (cfg_v_active),
        .cfg_v_fp     (cfg_v_fp),
        .cfg_v_sync   (cfg_v_sync),
        .cfg_v_bp     (cfg_v_bp),
        .cfg_hs_pol   (cfg_hs_pol),
        .cfg_vs_pol   (cfg_vs_pol),
        .cfg_update   (cfg_update),
`ifdef DISP_TG_LINE_IRQ_EN
        .cfg_irq_line (cfg_irq_line),
        .line_irq     (line_irq),
`endif
        .cfg_pending  (cfg_pending),
        .cfg_err      (cfg_err),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .frame_end    (frame_end)
    );

    typedef struct packed {
        logic         pend;
        logic         err;
        logic         de;
        logic         hs;
        logic         vs;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ls;
        logic         fs;
        logic         fe;
        logic         irq;
    } out_t;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int hp, vp;
        int legal, ht, vt;
        int ncyc;
    } row_t;

    row_t tab[10];
    row_t zr;
    out_t q[$];
    out_t last;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   prev_err = 1'b0;

    function automatic out_t f_inact(row_t r, bit pend, bit err);
        out_t o = '0;
        o.pend = pend;
        o.err  = err;
        o.hs   = (r.hp == 0);
        o.vs   = (r.vp == 0);
        return o;
    endfunction

    function automatic out_t f_rast(row_t r, int k, bit pend);
        out_t o = '0;
        int   h, v;
        bit   a;
        h = k % r.ht;
        v = (k / r.ht) % r.vt;
        o.pend = pend;
        o.de   = (h < r.ha) && (v < r.va);
        a      = (h >= r.ha + r.hf) && (h < r.ha + r.hf + r.hs);
        o.hs   = (r.hp != 0) ? a : !a;
        a      = (v >= r.va + r.vf) && (v < r.va + r.vf + r.vs);
        o.vs   = (r.vp != 0) ? a : !a;
        if (o.de) begin
            o.x = W'(h);
            o.y = W'(v);
        end
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        o.fe = (h == r.ht - 1) && (v == r.vt - 1);
`ifdef DISP_TG_LINE_IRQ_EN
        o.irq = (h == 0) && (v == IRQ_LINE);
`endif
        return o;
    endfunction

    function automatic out_t f_sample();
        out_t o;
        o.pend = cfg_pending;
        o.err  = cfg_err;
        o.de   = de;
        o.hs   = hsync;
        o.vs   = vsync;
        o.x    = pix_x;
        o.y    = pix_y;
        o.ls   = line_start;
        o.fs   = frame_start;
        o.fe   = frame_end;
`ifdef DISP_TG_LINE_IRQ_EN
        o.irq  = line_irq;
`else
        o.irq  = 1'b0;
`endif
        return o;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(out_t e, string nm);
        out_t x;
        q.push_back(e);
        @(negedge pixel_clk);
        last = f_sample();
        x = q.pop_front();
        chk(nm, 64'(last), 64'(x));
    endtask

    task automatic set_cfg(row_t r);
        cfg_h_active = W'(r.ha);
        cfg_h_fp     = W'(r.hf);
        cfg_h_sync   = W'(r.hs);
        cfg_h_bp     = W'(r.hb);
        cfg_v_active = W'(r.va);
        cfg_v_fp     = W'(r.vf);
        cfg_v_sync   = W'(r.vs);
        cfg_v_bp     = W'(r.vb);
        cfg_hs_pol   = (r.hp != 0);
        cfg_vs_pol   = (r.vp != 0);
    endtask

    // Idle, capture the row as the shadow set, enable, check the LOAD cycle.
    task automatic start(int i);
        tg_enable  = 1'b0;
        cfg_update = 1'b0;
        repeat (2) @(negedge pixel_clk);
        set_cfg(tab[i]);
        cfg_update = 1'b1;
        @(negedge pixel_clk);
        cfg_update = 1'b0;
        tg_enable  = 1'b1;
        step(f_inact(tab[i], 1'b1, prev_err), $sformatf("load%0d", i));
    endtask

    initial begin
        int n;
        //          ha   hf hs hb va   vf vs vb hp vp ok ht    vt    ncyc
        tab[0] = '{8,    2, 3, 1, 4,    1, 2, 1, 1, 1, 1, 14,   8,    230};
        tab[1] = '{8,    2, 3, 1, 4,    1, 2, 1, 0, 1, 1, 14,   8,    30};
        tab[2] = '{6,    2, 3, 1, 4,    1, 2, 1, 1, 1, 1, 12,   8,    100};
        tab[3] = '{8,    2, 0, 1, 4,    1, 2, 1, 1, 1, 0, 11,   8,    6};
        tab[4] = '{1,    1, 1, 1, 1,    1, 1, 1, 0, 0, 1, 4,    4,    40};
        tab[5] = '{8189, 1, 1, 1, 1,    1, 1, 1, 1, 1, 1, 8192, 4,    40};
        tab[6] = '{8190, 1, 1, 1, 1,    1, 1, 1, 1, 1, 0, 8193, 4,    5};
        tab[7] = '{8,    2, 3, 1, 8190, 1, 1, 1, 1, 1, 0, 14,   8193, 5};
        tab[8] = '{8,    2, 3, 1, 4,    1, 2, 1, 1, 0, 1, 14,   8,    120};
        tab[9] = '{5,    2, 3, 1, 4,    1, 2, 1, 1, 1, 1, 11,   8,    20};
        zr = '{default: 0};

        rst_n      = 1'b0;
        tg_enable  = 1'b0;
        cfg_update = 1'b0;
        set_cfg(zr);
`ifdef DISP_TG_LINE_IRQ_EN
        cfg_irq_line = W'(IRQ_LINE);
`endif
        repeat (3) @(negedge pixel_clk);
        chk("reset", 64'(f_sample()), 64'(0));
        rst_n = 1'b1;
        step(f_inact(zr, 1'b0, 1'b0), "idle_after_reset");

        for (int i = 0; i < 10; i++) begin
            start(i);
            for (int t = 0; t < tab[i].ncyc; t++) begin
                step(tab[i].legal != 0 ? f_rast(tab[i], t, 1'b0)
                                       : f_inact(tab[i], 1'b0, 1'b1),
                     $sformatf("row%0d_t%0d", i, t));
            end
            prev_err = (tab[i].legal == 0);
        end

        // Mid-frame update to h_active=6; inputs restored after the pulse.
        start(0);
        for (int k = 0; k < 112; k++) begin
            if (k == 30) begin
                set_cfg(tab[2]);
                cfg_update = 1'b1;
            end else if (k == 31) begin
                cfg_update = 1'b0;
                set_cfg(tab[0]);
            end
            step(f_rast(tab[0], k, k >= 30), $sformatf("mid_old_k%0d", k));
        end
        n = 0;
        for (int k = 0; k < 96; k++) begin
            step(f_rast(tab[2], k, 1'b0), $sformatf("mid_new_k%0d", k));
            if (k < 12 && last.de) n++;
        end
        chk("de_per_line_after_update", 64'(n), 64'(6));

        // Illegal set (h_sync=0) at the frame end, then a legal recovery.
        prev_err = 1'b0;
        for (int k = 0; k < 96; k++) begin
            if (k == 10) begin
                set_cfg(tab[3]);
                cfg_update = 1'b1;
            end else if (k == 11) begin
                cfg_update = 1'b0;
            end
            step(f_rast(tab[2], k, k >= 10), $sformatf("bad_pre_k%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            step(f_inact(tab[3], 1'b0, 1'b1), $sformatf("bad_hold%0d", k));
        end
        set_cfg(tab[0]);
        cfg_update = 1'b1;
        step(f_inact(tab[0], 1'b1, 1'b1), "bad_capture");
        cfg_update = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(f_rast(tab[0], k, 1'b0), $sformatf("recover_k%0d", k));
        end
        prev_err = 1'b0;

        // Enable dropped at h=5, v=2, then re-enabled.
        start(0);
        for (int k = 0; k < 34; k++) begin
            step(f_rast(tab[0], k, 1'b0), $sformatf("drop_pre_k%0d", k));
        end
        tg_enable = 1'b0;
        step(f_inact(tab[0], 1'b0, 1'b0), "drop_idle0");
        step(f_inact(tab[0], 1'b0, 1'b0), "drop_idle1");
        tg_enable = 1'b1;
        step(f_inact(tab[0], 1'b0, 1'b0), "reenable_load");
        for (int k = 0; k < 20; k++) begin
            step(f_rast(tab[0], k, 1'b0), $sformatf("reenable_k%0d", k));
        end

        // Capture coincident with the frame-end reload waits one more frame.
        start(0);
        for (int k = 0; k < 112; k++) begin
            if (k == 50) begin
                set_cfg(tab[2]);
                cfg_update = 1'b1;
            end else if (k == 51) begin
                cfg_update = 1'b0;
            end
            step(f_rast(tab[0], k, k >= 50), $sformatf("coin_a_k%0d", k));
        end
        set_cfg(tab[9]);
        cfg_update = 1'b1;
        step(f_rast(tab[2], 0, 1'b1), "coin_b_k0");
        cfg_update = 1'b0;
        for (int k = 1; k < 96; k++) begin
            step(f_rast(tab[2], k, 1'b1), $sformatf("coin_b_k%0d", k));
        end
        for (int k = 0; k < 30; k++) begin
            step(f_rast(tab[9], k, 1'b0), $sformatf("coin_c_k%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
